// File: rtl/klingon_scan_display.sv
// ----------------------------------------------------------------------------
// klingon_scan_display
//   Time-multiplexed driver for a multi-digit Klingon-numeral 7-segment
//   display. New digit values are staged in a pending register and copied
//   into the displayed shadow register only at a frame wrap, so a frame
//   never mixes old and new digits. Each digit slot begins with a short
//   window in which all enables are off, so two digits are never lit at the
//   same time. Leading zeros can optionally be blanked.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   enable     in   1 = scan and drive, 0 = dark with counters held
//   load       in   capture strobe for value
//   value      in   packed digits, digit k = value[4k+3:4k], digit 0 = LSD
//   lz_blank   in   1 = blank leading zero digits (sampled every cycle)
//   seg        out  registered segment pattern, active high, [6:0]
//   digit_en   out  registered one-hot digit select, active high
//   frame_done out  one-cycle pulse at each frame wrap
// ----------------------------------------------------------------------------
module klingon_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]        r_div_cnt;
    logic [IDX_W-1:0]        r_dig_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic                    r_pending;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_digit_en;
    logic                    r_frame_done;

    logic                    w_slot_end;
    logic                    w_boundary;
    logic                    w_lit;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [3:0]              w_cur_nib;
    logic                    w_cur_lead_zero;
    logic                    w_blank_lz;

    function automatic logic [6:0] f_encode(input logic [3:0] nib);
        case (nib)
            4'd0:    f_encode = 7'b0111111;
            4'd1:    f_encode = 7'b0000001;
            4'd2:    f_encode = 7'b1000001;
            4'd3:    f_encode = 7'b1001001;
            4'd4:    f_encode = 7'b1100010;
            4'd5:    f_encode = 7'b1011100;
            4'd6:    f_encode = 7'b1010010;
            4'd7:    f_encode = 7'b1100100;
            4'd8:    f_encode = 7'b0110110;
            4'd9:    f_encode = 7'b1110110;
            default: f_encode = 7'b0000000;
        endcase
    endfunction

    assign w_slot_end = (r_div_cnt == DIV_LAST);
    assign w_boundary = enable && w_slot_end && (r_dig_idx == IDX_LAST);
    assign w_lit      = enable && (r_div_cnt >= BLANK_END);

    // Select the current digit's nibble and one-hot bit, and work out whether
    // every digit from the top down to the current one is zero. The scan runs
    // from the most significant digit so the running flag can be reused.
    always_comb begin
        logic zero_run;
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        zero_run        = 1'b1;
        w_onehot        = '0;
        w_cur_nib       = 4'd0;
        w_cur_lead_zero = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (r_shadow[4*k +: 4] == 4'd0);
            if (r_dig_idx == IDX_W'(k)) begin
                w_onehot[k]     = 1'b1;
                w_cur_nib       = r_shadow[4*k +: 4];
                w_cur_lead_zero = zero_run;
            end
        end
    end

    // Digit 0 always shows, so a value of all zeros still reads "0".
    assign w_blank_lz = lz_blank && (r_dig_idx != '0) && w_cur_lead_zero;

    // Scan counters: divider within a slot, digit index across slots.
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the values present before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_dig_idx <= '0;
        end else if (enable) begin
            if (!w_slot_end) begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end else begin
                r_div_cnt <= '0;
                r_dig_idx <= (r_dig_idx == IDX_LAST) ? '0 : r_dig_idx + 1'b1;
            end
        end
    end

    // Capture path. A load that lands on the boundary edge bypasses the
    // pending stage so it is not deferred by a whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow   <= '0;
            r_pend_val <= '0;
            r_pending  <= 1'b0;
        end else begin
            if (load) begin
                r_pend_val <= value;
            end
            if (w_boundary) begin
                r_pending <= 1'b0;
                if (load) begin
                    r_shadow <= value;
                end else if (r_pending) begin
                    r_shadow <= r_pend_val;
                end
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Registered outputs, one cycle behind the scan state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg        <= '0;
            r_digit_en   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_boundary;
            r_digit_en   <= w_lit ? w_onehot : '0;
            r_seg        <= (w_lit && !w_blank_lz) ? f_encode(w_cur_nib) : 7'b0;
        end
    end

    assign seg        = r_seg;
    assign digit_en   = r_digit_en;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_klingon_scan_display.sv
// ----------------------------------------------------------------------------
// tb_klingon_scan_display
//   Directed bench for klingon_scan_display with NUM_DIGITS=4, SCAN_DIV=8,
//   BLANK_CYC=2. One frame is 32 cycles; slot s occupies frame positions
//   8s..8s+7 and is lit at in-slot cycles 2..7. Outputs are sampled 1 time
//   unit after each rising edge; the edge that samples frame position p
//   produces the outputs for p. Each test starts on a frame boundary.
// ----------------------------------------------------------------------------
module tb_klingon_scan_display;

    localparam logic [6:0] E0 = 7'b0111111;
    localparam logic [6:0] E1 = 7'b0000001;
    localparam logic [6:0] E2 = 7'b1000001;
    localparam logic [6:0] E3 = 7'b1001001;
    localparam logic [6:0] E4 = 7'b1100010;
    localparam logic [6:0] E5 = 7'b1011100;
    localparam logic [6:0] E6 = 7'b1010010;
    localparam logic [6:0] E7 = 7'b1100100;
    localparam logic [6:0] E8 = 7'b0110110;
    localparam logic [6:0] E9 = 7'b1110110;
    localparam logic [6:0] EZ = 7'b0000000;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic        lz_blank;
    logic [6:0]  seg;
    logic [3:0]  digit_en;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    // Expected lit segment pattern per frame (up to 3) and slot.
    logic [6:0] exp_tab [0:2][0:3];

    klingon_scan_display #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (8),
        .BLANK_CYC  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        enable   = 1'b0;
        load     = 1'b0;
        value    = 16'h0000;
        lz_blank = 1'b0;
        #3;
        checks++;
        if (seg !== 7'b0 || digit_en !== 4'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_async seg=%b digit_en=%b frame_done=%b required 0 0 0",
                     seg, digit_en, frame_done);
        end
        enable = 1'b1;
        tick();
        tick();
        checks++;
        if (seg !== 7'b0 || digit_en !== 4'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_held seg=%b digit_en=%b frame_done=%b required 0 0 0",
                     seg, digit_en, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Test 1: free scan with shadow at its reset value of all zeros.
    task automatic test_scan();
        int pos, s, c;
        logic [3:0] e_en;
        logic [6:0] e_sg;
        for (int t = 0; t < 32; t++) begin
            pos = t; s = pos / 8; c = pos % 8;
            tick();
            e_en = (c >= 2) ? (4'b0001 << s) : 4'b0000;
            e_sg = (c >= 2) ? E0 : EZ;
            checks++;
            if (digit_en !== e_en || seg !== e_sg || frame_done !== (pos == 31)) begin
                failures++;
                $display("FAIL scan t=%0d digit_en=%b seg=%b frame_done=%b required %b %b %b",
                         t, digit_en, seg, frame_done, e_en, e_sg, pos == 31);
            end
        end
    endtask

    // Test 2: load mid-frame shows only after the next frame wrap.
    task automatic test_load();
        int pos, f, s, c;
        logic [3:0] e_en;
        logic [6:0] e_sg;
        exp_tab[0] = '{E0, E0, E0, E0};
        exp_tab[1] = '{E6, E7, E8, E9};
        for (int t = 0; t < 64; t++) begin
            pos = t % 32; f = t / 32; s = pos / 8; c = pos % 8;
            if (t == 10) begin load = 1'b1; value = 16'h9876; end
            tick();
            load = 1'b0;
            e_en = (c >= 2) ? (4'b0001 << s) : 4'b0000;
            e_sg = (c >= 2) ? exp_tab[f][s] : EZ;
            checks++;
            if (digit_en !== e_en || seg !== e_sg || frame_done !== (pos == 31)) begin
                failures++;
                $display("FAIL load t=%0d digit_en=%b seg=%b frame_done=%b required %b %b %b",
                         t, digit_en, seg, frame_done, e_en, e_sg, pos == 31);
            end
        end
    endtask

    // Test 3: two loads in one frame, the later one wins.
    task automatic test_last_wins();
        int pos, f, s, c;
        logic [3:0] e_en;
        logic [6:0] e_sg;
        exp_tab[0] = '{E6, E7, E8, E9};
        exp_tab[1] = '{E2, E2, E2, E2};
        for (int t = 0; t < 64; t++) begin
            pos = t % 32; f = t / 32; s = pos / 8; c = pos % 8;
            if (t == 5)  begin load = 1'b1; value = 16'h1111; end
            if (t == 20) begin load = 1'b1; value = 16'h2222; end
            tick();
            load = 1'b0;
            e_en = (c >= 2) ? (4'b0001 << s) : 4'b0000;
            e_sg = (c >= 2) ? exp_tab[f][s] : EZ;
            checks++;
            if (digit_en !== e_en || seg !== e_sg || frame_done !== (pos == 31)) begin
                failures++;
                $display("FAIL last_wins t=%0d digit_en=%b seg=%b frame_done=%b required %b %b %b",
                         t, digit_en, seg, frame_done, e_en, e_sg, pos == 31);
            end
        end
    endtask

    // Test 4: leading-zero blanking on 0050, then all zeros.
    task automatic test_lz();
        int pos, f, s, c;
        logic [3:0] e_en;
        logic [6:0] e_sg;
        lz_blank = 1'b1;
        exp_tab[0] = '{E2, E2, E2, E2};
        exp_tab[1] = '{E0, E5, EZ, EZ};
        exp_tab[2] = '{E0, EZ, EZ, EZ};
        for (int t = 0; t < 96; t++) begin
            pos = t % 32; f = t / 32; s = pos / 8; c = pos % 8;
            if (t == 3)  begin load = 1'b1; value = 16'h0050; end
            if (t == 40) begin load = 1'b1; value = 16'h0000; end
            tick();
            load = 1'b0;
            e_en = (c >= 2) ? (4'b0001 << s) : 4'b0000;
            e_sg = (c >= 2) ? exp_tab[f][s] : EZ;
            checks++;
            if (digit_en !== e_en || seg !== e_sg || frame_done !== (pos == 31)) begin
                failures++;
                $display("FAIL lz_blank t=%0d digit_en=%b seg=%b frame_done=%b required %b %b %b",
                         t, digit_en, seg, frame_done, e_en, e_sg, pos == 31);
            end
        end
    endtask

    // Test 5: nibbles 10..15 encode dark but count as nonzero, so in 0A03
    // the zero in digit 1 is not leading and must show.
    task automatic test_hex_nonzero();
        int pos, f, s, c;
        logic [3:0] e_en;
        logic [6:0] e_sg;
        exp_tab[0] = '{E0, EZ, EZ, EZ};
        exp_tab[1] = '{E3, EZ, EZ, EZ};
        exp_tab[2] = '{E3, E0, EZ, EZ};
        for (int t = 0; t < 96; t++) begin
            pos = t % 32; f = t / 32; s = pos / 8; c = pos % 8;
            if (t == 3)  begin load = 1'b1; value = 16'h00A3; end
            if (t == 40) begin load = 1'b1; value = 16'h0A03; end
            tick();
            load = 1'b0;
            e_en = (c >= 2) ? (4'b0001 << s) : 4'b0000;
            e_sg = (c >= 2) ? exp_tab[f][s] : EZ;
            checks++;
            if (digit_en !== e_en || seg !== e_sg || frame_done !== (pos == 31)) begin
                failures++;
                $display("FAIL hex_nonzero t=%0d digit_en=%b seg=%b frame_done=%b required %b %b %b",
                         t, digit_en, seg, frame_done, e_en, e_sg, pos == 31);
            end
        end
    endtask

    // lz_blank dropped live (digit 3 zero now shows); a load on the boundary
    // edge reaches the very next frame.
    task automatic test_boundary_load();
        int pos, f, s, c;
        logic [3:0] e_en;
        logic [6:0] e_sg;
        lz_blank = 1'b0;
        exp_tab[0] = '{E3, E0, EZ, E0};
        exp_tab[1] = '{E4, E3, E2, E1};
        for (int t = 0; t < 64; t++) begin
            pos = t % 32; f = t / 32; s = pos / 8; c = pos % 8;
            if (t == 31) begin load = 1'b1; value = 16'h1234; end
            tick();
            load = 1'b0;
            e_en = (c >= 2) ? (4'b0001 << s) : 4'b0000;
            e_sg = (c >= 2) ? exp_tab[f][s] : EZ;
            checks++;
            if (digit_en !== e_en || seg !== e_sg || frame_done !== (pos == 31)) begin
                failures++;
                $display("FAIL boundary_load t=%0d digit_en=%b seg=%b frame_done=%b required %b %b %b",
                         t, digit_en, seg, frame_done, e_en, e_sg, pos == 31);
            end
        end
    endtask

    // Test 6a: enable low for 5 cycles inside slot 2; scan resumes in place.
    task automatic test_enable();
        int pos, s, c;
        logic [3:0] e_en;
        logic [6:0] e_sg;
        logic       e_fd;
        exp_tab[0] = '{E4, E3, E2, E1};
        pos = 0;
        for (int i = 0; i < 37; i++) begin
            enable = !(i >= 20 && i < 25);
            tick();
            if (enable) begin
                s = pos / 8; c = pos % 8;
                e_en = (c >= 2) ? (4'b0001 << s) : 4'b0000;
                e_sg = (c >= 2) ? exp_tab[0][s] : EZ;
                e_fd = (pos == 31);
                pos++;
            end else begin
                e_en = 4'b0000;
                e_sg = EZ;
                e_fd = 1'b0;
            end
            checks++;
            if (digit_en !== e_en || seg !== e_sg || frame_done !== e_fd) begin
                failures++;
                $display("FAIL enable i=%0d digit_en=%b seg=%b frame_done=%b required %b %b %b",
                         i, digit_en, seg, frame_done, e_en, e_sg, e_fd);
            end
        end
        enable = 1'b1;
    endtask

    // Test 6b: reset asserted mid-slot clears outputs without a clock edge,
    // and the scan and shadow restart from zero.
    task automatic test_reset_mid();
        int s, c;
        logic [3:0] e_en;
        logic [6:0] e_sg;
        for (int t = 0; t < 4; t++) tick();
        checks++;
        if (digit_en !== 4'b0001 || seg !== E4) begin
            failures++;
            $display("FAIL pre_reset digit_en=%b seg=%b required 0001 %b", digit_en, seg, E4);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (seg !== 7'b0 || digit_en !== 4'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid seg=%b digit_en=%b frame_done=%b required 0 0 0",
                     seg, digit_en, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            s = t / 8; c = t % 8;
            tick();
            e_en = (c >= 2) ? (4'b0001 << s) : 4'b0000;
            e_sg = (c >= 2) ? E0 : EZ;
            checks++;
            if (digit_en !== e_en || seg !== e_sg || frame_done !== 1'b0) begin
                failures++;
                $display("FAIL post_reset t=%0d digit_en=%b seg=%b frame_done=%b required %b %b 0",
                         t, digit_en, seg, frame_done, e_en, e_sg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_last_wins();
        test_lz();
        test_hex_nonzero();
        test_boundary_load();
        test_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
